soc_clint: RTL

// - Core-local interruptor; sits upstream of the ariane core and drives its time_irq_i / ipi_i inputs.
// - Holds a 64-bit free-running mtime, one mtimecmp per hart and one msip bit per hart.
// - Registers are reached through a simple req/gnt register bus, fed by the SoC AXI-to-reg bridge.

---
 rtl/soc_pkg.sv | 27 ++
 rtl/soc_clint_tick.sv | 34 +++
 rtl/soc_clint.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// soc_pkg: SoC-level constants shared by the CLINT and its neighbours.
//   - CLINT_BASE_ADDR : base of the CLINT window in the SoC address map
//   - CLINT_*_OFFS    : register offsets inside the CLINT window
//   - apply_be        : byte-enable merge used for every 64-bit register write
package soc_pkg;

    localparam logic [63:0] CLINT_BASE_ADDR     = 64'h0000_0000_0200_0000;
    localparam int unsigned CLINT_MSIP_OFFS     = 32'h0000_0000;
    localparam int unsigned CLINT_MTIMECMP_OFFS = 32'h0000_4000;
    localparam int unsigned CLINT_MTIME_OFFS    = 32'h0000_BFF8;

    // Replace each byte of old_val whose enable bit is set with the matching
    // byte of new_val.
    function automatic logic [63:0] apply_be(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  be);
        logic [63:0] res;
        res = old_val;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_clint_tick.sv
// soc_clint_tick: mtime prescaler. Counts 0..PRESCALE-1 and raises tick_o
// for one cycle in the cycle whose rising edge wraps the counter back to 0.
// Ports:
//   clk_i  : system clock
//   rst_i  : synchronous, active-high reset (counter -> 0)
//   tick_o : one-cycle pulse, mtime advances on the edge that ends this cycle
module soc_clint_tick #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    // A 1-bit counter is kept even for PRESCALE=1; it then stays at 0 and
    // every cycle is a tick.
    localparam int unsigned    CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = ~rst_i & (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/soc_clint.sv
// soc_clint: core-local interruptor. Holds a 64-bit free-running mtime, one
// mtimecmp and one msip bit per hart, and drives the per-hart timer and
// software interrupt lines of the core.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_i, we_i, addr_i,
//   wdata_i, be_i           : register-bus request (byte address, bits [2:0] ignored)
//   gnt_o                   : request accepted (combinational)
//   rvalid_o, rdata_o, err_o: response, one cycle after gnt_o
//   time_irq_o              : per-hart timer interrupt (mtime >= mtimecmp)
//   ipi_o                   : per-hart software interrupt (msip bit)
//
// Bus handshake: a request is taken whenever req_i=1 and the block is out of
// reset (gnt_o = req_i & ~rst_i); there is no back-pressure, so a request
// every cycle is accepted every cycle. Every grant produces exactly one
// rvalid_o pulse on the following cycle carrying rdata_o/err_o. Writes take
// effect on the grant edge; reads return the value held before that edge.
module soc_clint
    import soc_pkg::*;
#(
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [63:0]          wdata_i,
    input  logic [7:0]           be_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [63:0]          rdata_o,
    output logic                 err_o,
    output logic [NUM_HARTS-1:0] time_irq_o,
    output logic [NUM_HARTS-1:0] ipi_o
);

    logic                        tick;

    logic [63:0]                 mtime_q, mtime_d;
    logic [NUM_HARTS-1:0][63:0]  cmp_q, cmp_d;
    logic [NUM_HARTS-1:0]        msip_q, msip_d;
    logic [NUM_HARTS-1:0]        irq_d;

    logic [ADDR_W-1:0]           addr_al;
    logic                        mtime_sel;
    logic [NUM_HARTS-1:0]        msip_sel;
    logic [NUM_HARTS-1:0]        cmp_sel;
    logic                        mapped;
    logic                        wr;
    logic [63:0]                 rd_data;

    logic                        rvalid_q;
    logic [63:0]                 rdata_q;
    logic                        err_q;
    logic [NUM_HARTS-1:0]        time_irq_q;
    logic [NUM_HARTS-1:0]        ipi_q;

    // Low address bits only select a byte inside a 64-bit register.
    logic                        unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[2:0];

    soc_clint_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    assign gnt_o = req_i & ~rst_i;

    // Address decode and read mux.
    always_comb begin
        addr_al   = {addr_i[ADDR_W-1:3], 3'b000};
        mtime_sel = (addr_al == ADDR_W'(CLINT_MTIME_OFFS));
        msip_sel  = '0;
        cmp_sel   = '0;
        rd_data   = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            msip_sel[h] = (addr_al == ADDR_W'(CLINT_MSIP_OFFS + 8 * h));
            cmp_sel[h]  = (addr_al == ADDR_W'(CLINT_MTIMECMP_OFFS + 8 * h));
        end
        mapped = mtime_sel | (|msip_sel) | (|cmp_sel);
        if (mtime_sel) begin
            rd_data = mtime_q;
        end
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (msip_sel[h]) begin
                rd_data = {63'd0, msip_q[h]};
            end
            if (cmp_sel[h]) begin
                rd_data = cmp_q[h];
            end
        end
    end

    // A write with no byte enabled is a no-op and does not block a tick.
    assign wr = gnt_o & we_i & (|be_i);

    // Next-state values; the comparators look at these so the interrupt
    // lines update on the same edge as the registers they depend on.
    always_comb begin
        mtime_d = mtime_q;
        if (wr && mtime_sel) begin
            mtime_d = apply_be(mtime_q, wdata_i, be_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        cmp_d  = cmp_q;
        msip_d = msip_q;
        irq_d  = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (wr && cmp_sel[h]) begin
                cmp_d[h] = apply_be(cmp_q[h], wdata_i, be_i);
            end
            if (wr && msip_sel[h] && be_i[0]) begin
                msip_d[h] = wdata_i[0];
            end
            irq_d[h] = (mtime_d >= cmp_d[h]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            cmp_q      <= '1;
            msip_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            time_irq_q <= '0;
            ipi_q      <= '0;
        end else begin
            mtime_q    <= mtime_d;
            cmp_q      <= cmp_d;
            msip_q     <= msip_d;
            rvalid_q   <= gnt_o;
            rdata_q    <= (gnt_o && !we_i && mapped) ? rd_data : 64'd0;
            err_q      <= gnt_o & ~mapped;
            time_irq_q <= irq_d;
            ipi_q      <= msip_d;
        end
    end

    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign err_o      = err_q;
    assign time_irq_o = time_irq_q;
    assign ipi_o      = ipi_q;

endmodule
